cont4b_disp: RTL and testbench

- Downstream display stage for the 4-bit up/down counter: consumes the counter value `sal[3:0]` and its direction control, and drives a 4-digit multiplexed 7-segment display.
- Shows the value in decimal (0-15) on the two rightmost digits with leading-zero blanking. Digit 2 is blank. Digit 3 shows 'U' (up) or 'd' (down).
- Inputs are sampled once per scan frame so a frame never mixes two counter values.

---
 rtl/cont4b_disp.sv | 110 +++++++++++
 tb/tb_cont4b_disp.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cont4b_disp.sv
// Four-digit multiplexed 7-segment driver for the 4-bit up/down counter.
// Shows the value in decimal on the right two digits and the direction ('U'/'d') on the leftmost digit.
module cont4b_disp #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       dir,
  input  logic       en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            PW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TC_VAL = PW'(REFRESH_DIV - 1);
  localparam logic          INV    = !ACTIVE_LOW;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_lat_val;
  logic          r_lat_dir;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_tc;
  logic [3:0]    w_ones;
  logic [6:0]    w_seg_ones;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;

  always_comb begin
    w_tc   = (r_presc == TC_VAL);
    w_ones = (r_lat_val >= 4'd10) ? (r_lat_val - 4'd10) : r_lat_val;

    case (w_ones)
      4'd0:    w_seg_ones = SEG_0;
      4'd1:    w_seg_ones = SEG_1;
      4'd2:    w_seg_ones = SEG_2;
      4'd3:    w_seg_ones = SEG_3;
      4'd4:    w_seg_ones = SEG_4;
      4'd5:    w_seg_ones = SEG_5;
      4'd6:    w_seg_ones = SEG_6;
      4'd7:    w_seg_ones = SEG_7;
      4'd8:    w_seg_ones = SEG_8;
      4'd9:    w_seg_ones = SEG_9;
      default: w_seg_ones = SEG_BLANK;
    endcase

    case (r_idx)
      2'd0:    w_seg_nxt = w_seg_ones;
      2'd1:    w_seg_nxt = (r_lat_val >= 4'd10) ? SEG_1 : SEG_BLANK;
      2'd3:    w_seg_nxt = r_lat_dir ? SEG_D : SEG_U;
      default: w_seg_nxt = SEG_BLANK;
    endcase

    w_an_nxt = ~(4'b0001 << r_idx);

    // Disable only blanks the outputs; the scan timing keeps running
    if (!en) begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_idx     <= 2'd0;
      r_lat_val <= 4'd0;
      r_lat_dir <= 1'b0;
      r_an      <= {4{INV}} ^ 4'b1111;
      r_seg     <= {7{INV}} ^ SEG_BLANK;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + 1'b1;
      if (w_tc) begin
        r_idx <= r_idx + 2'd1;
        // Latch only at the frame boundary so one frame never mixes two values
        if (r_idx == 2'd3) begin
          r_lat_val <= value;
          r_lat_dir <= dir;
        end
      end
      r_an  <= {4{INV}} ^ w_an_nxt;
      r_seg <= {7{INV}} ^ w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1 ^ INV;

endmodule

// File: tb/tb_cont4b_disp.sv
// Scoreboard bench for cont4b_disp: the driver queues the expected {an,seg,dp} for each cycle,
// and the monitor pops and compares one entry after every clock edge.
module tb_cont4b_disp;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SU = 7'b1000001;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [3:0] AOFF = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] value = 4'd0;
  logic       dir = 1'b0;
  logic       en = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  logic [11:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  cont4b_disp #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .dir   (dir),
    .en    (en),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  // Monitor: one output per cycle, compared against the oldest queued expectation
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({an, seg, dp} !== e) begin
          n_fail++;
          $display("FAIL disp cyc %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
      end
    end
  end

  task automatic step(input logic r, input logic e_n, input logic [3:0] v, input logic d,
                      input logic [3:0] x_an, input logic [6:0] x_seg);
    @(negedge clk);
    rst   = r;
    en    = e_n;
    value = v;
    dir   = d;
    exp_q.push_back({x_an, x_seg, 1'b1});
  endtask

  // One 16-cycle frame starting right after an idx 3->0 wrap (or reset release).
  // e0..e3: hand-derived seg per digit; value switches v_a->v_b at frame cycle chg_at;
  // en low for cycles off_lo..off_hi; rst asserted at cycle rst_at ends the frame early.
  task automatic run_frame(input logic [6:0] e0, e1, e2, e3,
                           input logic [3:0] v_a, v_b, input int chg_at, input logic d,
                           input int off_lo, off_hi, input int rst_at);
    for (int k = 1; k <= 16; k++) begin
      int         dig;
      logic       e_n;
      logic [3:0] x_an;
      logic [6:0] x_seg;
      dig = (k - 1) / 4;
      if (k == rst_at) begin
        step(1'b1, 1'b1, v_a, d, AOFF, SB);
        return;
      end
      e_n = !(k >= off_lo && k <= off_hi);
      case (dig)
        0:       begin x_an = 4'b1110; x_seg = e0; end
        1:       begin x_an = 4'b1101; x_seg = e1; end
        2:       begin x_an = 4'b1011; x_seg = e2; end
        default: begin x_an = 4'b0111; x_seg = e3; end
      endcase
      if (!e_n) begin
        x_an  = AOFF;
        x_seg = SB;
      end
      step(1'b0, e_n, (k < chg_at) ? v_a : v_b, d, x_an, x_seg);
    end
  endtask

  initial begin
    // Reset held with value 9 present
    repeat (3) step(1'b1, 1'b1, 4'd9, 1'b0, AOFF, SB);
    // "U  0" until first latch; 9 latched at the end of this frame
    run_frame(S0, SB, SB, SU, 4'd9, 4'd9, 17, 1'b0, 0, -1, 0);
    run_frame(S9, SB, SB, SU, 4'd13, 4'd13, 17, 1'b1, 0, -1, 0);
    // 13 counting down
    run_frame(S3, S1, SB, SD, 4'd10, 4'd10, 17, 1'b1, 0, -1, 0);
    // 10 then 9 on consecutive frames
    run_frame(S0, S1, SB, SD, 4'd9, 4'd9, 17, 1'b1, 0, -1, 0);
    run_frame(S9, SB, SB, SD, 4'd12, 4'd12, 17, 1'b1, 0, -1, 0);
    // 12 shown while value moves to 5 at frame cycle 6
    run_frame(S2, S1, SB, SD, 4'd12, 4'd5, 6, 1'b0, 0, -1, 0);
    // 5 shown, en low for cycles 5..12
    run_frame(S5, SB, SB, SU, 4'd15, 4'd15, 17, 1'b0, 5, 12, 0);
    // 15 shown with phase intact after the blanked window
    run_frame(S5, S1, SB, SU, 4'd15, 4'd15, 17, 1'b0, 0, -1, 0);
    // Reset at frame cycle 10 with 15 latched
    run_frame(S5, S1, SB, SU, 4'd15, 4'd15, 17, 1'b0, 0, -1, 10);
    // Restart shows 0 until the next latch, then 3
    run_frame(S0, SB, SB, SU, 4'd3, 4'd3, 17, 1'b0, 0, -1, 0);
    run_frame(S3, SB, SB, SU, 4'd3, 4'd3, 17, 1'b0, 0, -1, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
